// File: rtl/alu_pkg.sv
// Shared opcodes, MDU state type and opcode helpers for the execute stage.
// MDU_DIV_EN selects whether DIVU/REMU are legal opcodes.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return !op[3];
  endfunction

  function automatic logic is_mdu_op(input logic [3:0] op);
`ifdef MDU_DIV_EN
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
`else
    return op inside {OP_MUL, OP_MULHU};
`endif
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide.
// The divide datapath exists only when MDU_DIV_EN is defined.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [4:0]   rd_i,
  output logic         idle_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [4:0]   rd_o,
  output logic [W-1:0] res_o
);

  localparam int CW = $clog2(W);

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [3:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;

  logic [W:0]     msum;
  logic [2*W-1:0] mul_acc;

  // Low half holds the multiplier (or dividend/quotient) and drains right.
  assign msum    = {1'b0, acc_q[2*W-1:W]}
                 + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
  assign mul_acc = {msum, acc_q[W-1:1]};

`ifdef MDU_DIV_EN
  logic [W:0] rem_q, rem_d, rem_sh, diff;
  logic       ge, is_div, unused_rem;

  assign rem_sh     = {rem_q[W-1:0], acc_q[W-1]};
  assign diff       = rem_sh - {1'b0, opb_q};
  assign ge         = !diff[W];
  assign is_div     = op_q inside {OP_DIVU, OP_REMU};
  assign unused_rem = rem_q[W];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    rd_d    = rd_q;
`ifdef MDU_DIV_EN
    rem_d   = rem_q;
`endif
    unique case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = CW'(W-1);
          acc_d   = {{W{1'b0}}, a_i};
          opb_d   = b_i;
          op_d    = op_i;
          rd_d    = rd_i;
`ifdef MDU_DIV_EN
          rem_d   = '0;
`endif
        end
      end
      MDU_BUSY: begin
`ifdef MDU_DIV_EN
        if (is_div) begin
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], ge};
          rem_d = ge ? diff : rem_sh;
        end else begin
          acc_d = mul_acc;
        end
`else
        acc_d = mul_acc;
`endif
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = MDU_DONE;
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
`ifdef MDU_DIV_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
`ifdef MDU_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

  always_comb begin
    res_o = acc_q[W-1:0];
    unique case (1'b1)
      (op_q == OP_MULHU): res_o = acc_q[2*W-1:W];
`ifdef MDU_DIV_EN
      (op_q == OP_REMU):  res_o = rem_q[W-1:0];
`endif
      default:            res_o = acc_q[W-1:0];
    endcase
  end

  assign idle_o = (state_q == MDU_IDLE);
  assign busy_o = (state_q == MDU_BUSY);
  assign done_o = (state_q == MDU_DONE);
  assign rd_o   = rd_q;

endmodule

// File: rtl/alu_mdu_top.sv
// Execute stage: regfile, ALUsrc mux, single-cycle ALU and iterative MDU.
// MDU_DIV_EN enables DIVU/REMU; otherwise they decode as illegal.
module alu_mdu_top
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              Instr,
  input  logic                     ALUsrc,
  input  logic [CONTROL_WIDTH-1:0] ALUctrl,
  input  logic                     RegWrite,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     EQ,
  output logic [DATA_WIDTH-1:0]    a0,
  output logic                     stall,
  output logic                     illegal_op
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] rf_q [32];
  logic [4:0]            rs1, rs2, rd;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] srca, srcb, alu_res;
  logic                  issue, sc_we, unused_instr;
  logic                  mdu_idle, mdu_busy, mdu_done;
  logic [4:0]            mdu_rd;
  logic [DATA_WIDTH-1:0] mdu_res;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  assign rs1 = Instr[19:15];
  assign rs2 = Instr[24:20];
  assign rd  = Instr[11:7];
  assign op  = 4'(ALUctrl);

  assign unused_instr = ^{Instr[31:25], Instr[14:12], Instr[6:0]};

  assign srca = rf_q[rs1];
  assign srcb = ALUsrc ? ImmOp : rf_q[rs2];
  assign EQ   = (srca == srcb);
  assign a0   = rf_q[10];

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = srca + srcb;
      OP_SUB:  alu_res = srca - srcb;
      OP_AND:  alu_res = srca & srcb;
      OP_OR:   alu_res = srca | srcb;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}},
                          ($signed(srca) < $signed(srcb))};
      OP_XOR:  alu_res = srca ^ srcb;
      OP_SLL:  alu_res = srca << srcb[SHW-1:0];
      OP_SRL:  alu_res = srca >> srcb[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // New work is only accepted while the MDU sits idle.
  assign issue      = !rst && RegWrite && mdu_idle && is_mdu_op(op);
  assign stall      = !rst && (mdu_busy || issue);
  assign illegal_op = !rst && RegWrite && mdu_idle
                    && !is_alu_op(op) && !is_mdu_op(op);
  assign sc_we      = RegWrite && mdu_idle && !stall && is_alu_op(op);

  mdu_iter #(
    .W (DATA_WIDTH)
  ) u_mdu (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (issue),
    .op_i    (op),
    .a_i     (srca),
    .b_i     (srcb),
    .rd_i    (rd),
    .idle_o  (mdu_idle),
    .busy_o  (mdu_busy),
    .done_o  (mdu_done),
    .rd_o    (mdu_rd),
    .res_o   (mdu_res)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = alu_res;
    if (mdu_done) begin
      wr_en   = 1'b1;
      wr_addr = mdu_rd;
      wr_data = mdu_res;
    end else if (sc_we) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_alu_mdu_top.sv
// Randomised bench for alu_mdu_top against an arithmetic reference model.
// Registers are observed through a0 and through EQ with an immediate probe.
module tb_alu_mdu_top;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   Instr;
  logic          ALUsrc;
  logic [3:0]    ALUctrl;
  logic          RegWrite;
  logic [W-1:0]  ImmOp;
  logic          EQ;
  logic [W-1:0]  a0;
  logic          stall;
  logic          illegal_op;

  logic [W-1:0]  m [32];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            div_en;

  always #5 clk = ~clk;

  alu_mdu_top #(
    .DATA_WIDTH    (W),
    .CONTROL_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Instr      (Instr),
    .ALUsrc     (ALUsrc),
    .ALUctrl    (ALUctrl),
    .RegWrite   (RegWrite),
    .ImmOp      (ImmOp),
    .EQ         (EQ),
    .a0         (a0),
    .stall      (stall),
    .illegal_op (illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 0 = single-cycle, 1 = multi-cycle, 2 = illegal
  function automatic int kind(input logic [3:0] op);
    if (op < 8) return 0;
    if (op == 8 || op == 9) return 1;
    if ((op == 10 || op == 11) && div_en) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a << (b % 32);
      4'd7:  return a >> (b % 32);
      4'd8:  return p[31:0];
      4'd9:  return p[63:32];
      4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input int rd, input int rs1,
                       input int rs2, input logic src,
                       input logic [31:0] imm, input logic we);
    Instr    = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    ALUctrl  = op;
    ALUsrc   = src;
    ImmOp    = imm;
    RegWrite = we;
  endtask

  // Called just after a rising edge; returns just after a later rising edge.
  task automatic exec(input logic [3:0] op, input int rd, input int rs1,
                      input int rs2, input logic src,
                      input logic [31:0] imm, input logic we);
    logic [31:0] a, b, res;
    int k, cyc;
    drive(op, rd, rs1, rs2, src, imm, we);
    a   = m[rs1];
    b   = src ? imm : m[rs2];
    k   = kind(op);
    res = ref_result(op, a, b);
    @(negedge clk);
    check("eq", EQ, 32'(a == b));
    check("a0", a0, m[10]);
    check("illegal_op", illegal_op, 32'(we && k == 2));
    if (we && k == 1) begin
      cyc = 0;
      while (stall === 1'b1 && cyc < 3 * W) begin
        cyc++;
        @(negedge clk);
      end
      check("stall_len", cyc, W + 1);
      check("a0_before_done", a0, m[10]);
      check("eq_stalled", EQ, 32'(a == b));
      @(posedge clk);
      #1;
      if (rd != 0) m[rd] = res;
    end else begin
      check("stall", stall, 0);
      @(posedge clk);
      #1;
      if (we && k == 0 && rd != 0) m[rd] = res;
    end
  endtask

  task automatic check_reg(input int r);
    drive(4'd0, 0, r, 0, 1'b1, m[r], 1'b0);
    @(negedge clk);
    check($sformatf("x%0d_eq", r), EQ, 1);
    ImmOp = m[r] ^ 32'h1;
    #1;
    check($sformatf("x%0d_ne", r), EQ, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] seen;
`ifdef MDU_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    for (int i = 0; i < 32; i++) m[i] = '0;
    rst = 1'b1;
    drive(4'd0, 0, 0, 0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_a0", a0, 0);
    check("rst_stall", stall, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_eq", EQ, 1);
    @(posedge clk);
    #1;

    exec(4'd0, 10, 0, 0, 1'b1, 32'd5, 1'b1);
    check("a0_add5", a0, 32'd5);
    exec(4'd1, 10, 10, 0, 1'b1, 32'd2, 1'b1);
    check("a0_sub2", a0, 32'd3);

    exec(4'd0, 1, 0, 0, 1'b1, 32'd7, 1'b1);
    exec(4'd0, 2, 0, 0, 1'b1, 32'd6, 1'b1);
    exec(4'd8, 3, 1, 2, 1'b0, 32'd0, 1'b1);
    check_reg(3);
    exec(4'd0, 4, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    exec(4'd9, 5, 4, 4, 1'b0, 32'd0, 1'b1);
    check_reg(5);

    exec(4'd0, 6, 0, 0, 1'b1, 32'd100, 1'b1);
    exec(4'd0, 7, 0, 0, 1'b1, 32'd7, 1'b1);
    exec(4'd0, 12, 0, 0, 1'b1, 32'd9, 1'b1);
    exec(4'd10, 8, 6, 7, 1'b0, 32'd0, 1'b1);
    exec(4'd11, 9, 6, 7, 1'b0, 32'd0, 1'b1);
    exec(4'd10, 11, 6, 0, 1'b0, 32'd0, 1'b1);
    exec(4'd11, 13, 12, 0, 1'b0, 32'd0, 1'b1);
    check_reg(8);
    check_reg(9);
    check_reg(11);
    check_reg(13);

    exec(4'd13, 14, 1, 2, 1'b0, 32'd0, 1'b1);
    check_reg(14);
    exec(4'd8, 0, 1, 2, 1'b0, 32'd0, 1'b1);
    check_reg(0);

    for (int i = 0; i < 250; i++) begin
      logic [31:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20))
                                        : 32'($urandom);
      exec(4'($urandom_range(0, 15)), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15),
           1'($urandom_range(0, 1)), imm,
           1'($urandom_range(0, 7) != 0));
    end
    for (int r = 0; r < 32; r++) check_reg(r);

    // Reset in the middle of a multiply targeting x10
    exec(4'd0, 10, 0, 0, 1'b1, 32'h1234, 1'b1);
    exec(4'd0, 1, 0, 0, 1'b1, 32'd7, 1'b1);
    exec(4'd0, 2, 0, 0, 1'b1, 32'd6, 1'b1);
    drive(4'd8, 10, 1, 2, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    check("rst_issue_stall", stall, 1);
    repeat (10) @(posedge clk);
    #1;
    check("busy10_stall", stall, 1);
    rst      = 1'b1;
    RegWrite = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    @(negedge clk);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_a0", a0, 0);
    seen = '0;
    repeat (W + 5) begin
      @(negedge clk);
      seen = seen | a0;
    end
    check("no_late_write", seen, 0);
    @(posedge clk);
    #1;
    check_reg(1);
    check_reg(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mdu_top.md
# alu_mdu_top

Execute-stage datapath for the single-cycle core: a 32-entry register file, the ALUsrc operand mux and the single-cycle ALU, plus an iterative multiply/divide unit (MDU) for the M-extension unsigned subset. Single-cycle operations keep their existing timing. MDU operations occupy the unit for a fixed number of cycles and stall the front end through a `stall` output. It replaces the plain ALU/regfile wrapper in the top level and is parametrised in data width.

## Interface
- `DATA_WIDTH`, 32: operand, register and result width.
- `CONTROL_WIDTH`, 4: ALUctrl width. It grows from 3 to 4 bits to carry the MDU opcodes.
- `clk`  in  1  : single clock. All state updates on its rising edge.
- `rst`  in  1  : reset, synchronous and active-high.
- `Instr`  in  32 : instruction word. Fields are rs1=[19:15], rs2=[24:20], rd=[11:7].
- `ALUsrc`  in  1 : 0 selects rs2 data as SrcB; 1 selects ImmOp.
- `ALUctrl`  in  CONTROL_WIDTH : operation code (encoding under Operation).
- `RegWrite`  in  1 : write enable for single-cycle results. Also acts as the issue qualifier for MDU ops.
- `ImmOp`  in  DATA_WIDTH : sign-extended immediate.
- `EQ`  out  1 : SrcA == SrcB, combinational.
- `a0`  out  DATA_WIDTH : live contents of x10.
- `stall`  out  1 : front end must hold PC and Instr while high.
- `illegal_op`  out  1 : one-cycle pulse when an unsupported opcode is presented with RegWrite=1.

## Operation
- **ALUctrl codes**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 XOR, 6 SLL, 7 SRL: single-cycle.
  - 8 MUL (low half), 9 MULHU (high half, unsigned), 10 DIVU, 11 REMU: MDU.
  - 12–15: illegal.
- **Register file**
  - 32 × DATA_WIDTH.
  - Two combinational reads, one synchronous write.
  - Writes to x0 are dropped; x0 always reads 0.
- **Single-cycle path**
  - A single-cycle op writes ALU result to rd at the clock edge when RegWrite=1 and state is IDLE.
  - The write is suppressed when stall=1.
- **MDU FSM: IDLE → BUSY → DONE → IDLE.**
  - IDLE: an MDU opcode with RegWrite=1 issues.
    - Latch SrcA, SrcB, rd and opcode.
    - Load the counter with DATA_WIDTH−1.
    - Go to BUSY.
    - No regfile write occurs in the issue cycle.
  - BUSY: one iteration per cycle.
    - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand to the 2W-bit accumulator upper half, then shift right.
    - Divide: restoring; remainder/quotient shift and subtract.
    - The counter decrements; when it reaches 0, go to DONE.
  - DONE: write the selected result to the latched rd at the clock edge, then go to IDLE.
    - The still-presented MDU instruction does not re-issue from DONE.
- **Result selection**
  - MUL = product[W−1:0]; MULHU = product[2W−1:W].
  - DIVU = quotient; REMU = remainder.
- **Division by zero**: DIVU writes all-ones and REMU writes the dividend. The full iteration count is still taken.
- **Width rules**
  - Shifts use SrcB[$clog2(DATA_WIDTH)−1:0].
  - The accumulator is 2·DATA_WIDTH bits; the remainder register is DATA_WIDTH+1 bits.
- **Illegal opcode** (12–15, or 10/11 when division is compiled out): no write, no issue, illegal_op=1 for that cycle.

## Timing
- Reset values: state IDLE, stall=0, illegal_op=0, all registers 0, so a0=0 and EQ reflects the reset register contents.
- stall is a registered-state decode: high in the issue cycle and in all BUSY cycles, low in DONE.
- MDU latency: issue cycle, then DATA_WIDTH BUSY cycles, then the DONE cycle. The result is visible in the regfile DATA_WIDTH+2 edges after issue, and stall is high for DATA_WIDTH+1 cycles.
- Back-to-back MDU ops: the second issues in the cycle after DONE at the earliest.
- An MDU op whose rd equals a following instruction's rs sees the updated value, because the following instruction is presented only after DONE.
- rst asserted in any state: next state is IDLE, stall drops after the edge, the partial result is discarded, rd is not written, and all registers clear.
- EQ stays combinational on the presented instruction, including while stalled.

## Configuration
- `MDU_DIV_EN` defined: the DIVU/REMU datapath (divisor register, remainder register, subtractor) is built.
- Undefined: codes 10/11 are treated as illegal and only the multiply path exists.

## Structure
- Shared package `alu_pkg`:
  - ALUctrl opcode constants.
  - MDU state enum (IDLE/BUSY/DONE).
  - `is_mdu_op` helper function.
- Sub-module `mdu_iter` contains the FSM, counter, accumulator and divider with a start/done interface. The top level keeps the regfile, mux, ALU and write-port arbitration.

## Test plan
- ADD x10 = x0 + ImmOp 5, then SUB x10 = x10 − imm(ALUsrc=1) 2 → a0=5 then a0=3, stall never rises.
- MUL with rs1=7, rs2=6 → stall high 33 cycles, then rd=42; MULHU of 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9 (MDU_DIV_EN defined).
- rst pulsed at BUSY cycle 10 of a MUL into rd=x10 → stall=0 after the edge, a0=0, and no later write occurs.
- ALUctrl=13 with RegWrite=1, or DIVU with MDU_DIV_EN undefined → illegal_op=1 for one cycle, no register changes.
- MUL writing rd=x0 → full stall duration completes, x0 reads 0 afterwards.
